seq_multiplier_nxm: RTL and testbench

Parametrised sequential shift-add multiplier, the successor to the fixed 4×3 combinational partial-product multiplier. It accepts an A_W-bit by B_W-bit operand pair through a valid/ready handshake, with per-transaction unsigned or two's-complement mode. It accumulates one partial product per clock and returns the exact (A_W+B_W)-bit product through a second valid/ready handshake. It sits in the arithmetic datapath wherever area matters more than throughput.

---
 rtl/mul_pkg.sv | 21 ++
 rtl/mul_pp_step.sv | 39 +++
 rtl/seq_multiplier_nxm.sv | 115 +++++++++++
 tb/tb_seq_multiplier_nxm.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and width helpers for the sequential N x M multiplier.
//   mul_state_e : controller state encoding (IDLE, RUN, DONE)
//   cnt_width   : width of the step counter for a given multiplier width
//   prod_width  : width of the exact product for given operand widths
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    function automatic int cnt_width(input int b_w);
        return $clog2(b_w + 1);
    endfunction

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

endpackage

// File: rtl/mul_pp_step.sv
// One shift-add step of the multiplier (purely combinational).
// Ports:
//   acc_i    : current accumulator
//   a_ext_i  : multiplicand, already sign/zero extended to product width
//   idx_i    : multiplier bit index of this step (shift amount)
//   bit_i    : multiplier bit value for this step
//   signed_i : operands are two's complement
//   last_i   : this is the MSB step of the multiplier
//   acc_o    : accumulator after this step
module mul_pp_step #(
    parameter int P_W   = 7,
    parameter int IDX_W = 2
) (
    input  logic [P_W-1:0]   acc_i,
    input  logic [P_W-1:0]   a_ext_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             bit_i,
    input  logic             signed_i,
    input  logic             last_i,
    output logic [P_W-1:0]   acc_o
);

    logic [P_W-1:0] pp;

    always_comb begin
        pp    = a_ext_i << idx_i;
        acc_o = acc_i;
        if (bit_i) begin
            // The signed multiplier MSB weighs -2^(B_W-1), so its partial
            // product is subtracted rather than added.
            if (signed_i && last_i) begin
                acc_o = acc_i - pp;
            end else begin
                acc_o = acc_i + pp;
            end
        end
    end

endmodule

// File: rtl/seq_multiplier_nxm.sv
// Sequential shift-add multiplier, A_W x B_W -> A_W+B_W, one multiplier bit
// per clock, unsigned or two's complement selected per transaction.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   a, b, is_signed      : operands and mode, captured on accept
//   out_valid / out_ready: product handshake (out_valid only in DONE)
//   p                    : registered product, held until the next result
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | accumulating one partial product per cycle for B_W cycles
// DONE  | product valid on p, waiting for out_ready
module seq_multiplier_nxm
    import mul_pkg::*;
#(
    parameter int A_W = 4,
    parameter int B_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] p
);

    localparam int P_W   = prod_width(A_W, B_W);
    localparam int CNT_W = cnt_width(B_W);
    localparam logic [CNT_W-1:0] LAST_REM = CNT_W'(B_W - 1);

    mul_state_e       state_q;
    logic [A_W-1:0]   a_q;
    logic [B_W-1:0]   b_q;
    logic             sgn_q;
    logic [P_W-1:0]   acc_q;
    logic [P_W-1:0]   acc_d;
    logic [P_W-1:0]   p_q;
    logic [CNT_W-1:0] rem_q;

    logic [P_W-1:0]   a_ext;
    logic [CNT_W-1:0] idx;
    logic             last;

    // rem_q counts remaining steps down to zero; the bit index is derived
    // from it. b_q is shifted right each step so its LSB is the current bit.
    always_comb begin
        a_ext = {{B_W{sgn_q & a_q[A_W-1]}}, a_q};
        idx   = LAST_REM - rem_q;
        last  = (rem_q == '0);
    end

    mul_pp_step #(
        .P_W  (P_W),
        .IDX_W(CNT_W)
    ) u_step (
        .acc_i   (acc_q),
        .a_ext_i (a_ext),
        .idx_i   (idx),
        .bit_i   (b_q[0]),
        .signed_i(sgn_q),
        .last_i  (last),
        .acc_o   (acc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
            rem_q   <= '0;
            p_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        sgn_q   <= is_signed;
                        acc_q   <= '0;
                        rem_q   <= LAST_REM;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    b_q   <= b_q >> 1;
                    if (last) begin
                        p_q     <= acc_d;
                        state_q <= DONE;
                    end else begin
                        rem_q <= rem_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = p_q;

endmodule

// File: tb/tb_seq_multiplier_nxm.sv
module tb_seq_multiplier_nxm;

    localparam int A_W = 4;
    localparam int B_W = 3;
    localparam int P_W = A_W + B_W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [A_W-1:0] a = '0;
    logic [B_W-1:0] b = '0;
    logic           is_signed = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [P_W-1:0] p;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc = 0;
    int n_hs = 0;
    logic [P_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    seq_multiplier_nxm #(.A_W(A_W), .B_W(B_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .is_signed(is_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [P_W-1:0] ref_prod(input logic [A_W-1:0] x, input logic [B_W-1:0] y,
                                                input logic s);
        int xv, yv, pr;
        logic [31:0] tmp;
        xv  = s ? int'($signed(x)) : int'(x);
        yv  = s ? int'($signed(y)) : int'(y);
        pr  = xv * yv;
        tmp = pr;
        return tmp[P_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge with the DUT in IDLE.
    task automatic do_txn(input logic [A_W-1:0] ta, input logic [B_W-1:0] tb, input logic ts,
                          input logic [P_W-1:0] e, input int stall, input bit rnd);
        int lat;
        int guard;
        bit done;
        logic [P_W-1:0] ev;
        chk("in_ready_idle", in_ready, 1'b1);
        a = ta; b = tb; is_signed = ts; in_valid = 1'b1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        exp_q.push_back(e);
        n_acc++;
        in_valid = 1'b0;
        a = A_W'($urandom); b = B_W'($urandom); is_signed = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        chk("latency", lat, B_W);
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            in_valid = 1'b1;
            a = A_W'($urandom); b = B_W'($urandom); is_signed = 1'($urandom);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_p", p, e);
            tick();
        end
        in_valid = 1'b0;
        done = 1'b0;
        guard = 0;
        while (!done && guard < 64) begin
            chk("done_out_valid", out_valid, 1'b1);
            chk("done_p_hold", p, exp_q[0]);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            guard++;
            if (out_ready) begin
                done = 1'b1;
                n_hs++;
                ev = exp_q.pop_front();
                chk("product", p, ev);
                chk("in_ready_after_release", in_ready, 1'b1);
                chk("out_valid_after_release", out_valid, 1'b0);
            end
        end
        if (!done) begin
            chk("release_timeout", 1'b0, 1'b1);
            void'(exp_q.pop_front());
        end
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset and idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_p", p, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_in_ready", in_ready, 1'b1);
            chk("idle_out_valid", out_valid, 1'b0);
            chk("idle_p", p, 0);
        end

        // Directed corners
        do_txn(4'd15, 3'd7, 1'b0, 7'h69, 0, 1'b0);
        do_txn(4'b1000, 3'b100, 1'b1, 7'd32, 0, 1'b0);
        do_txn(4'd7, 3'b100, 1'b1, 7'h64, 0, 1'b0);
        do_txn(4'b1111, 3'd3, 1'b1, 7'h7D, 0, 1'b0);

        // Backpressure: 10 stalled cycles with in_valid asserted
        do_txn(4'd6, 3'd5, 1'b0, 7'd30, 10, 1'b0);

        // Reset in the middle of RUN
        a = 4'd5; b = 3'd3; is_signed = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_p", p, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_out_valid", out_valid, 1'b0);
        end
        do_txn(4'd3, 3'd2, 1'b0, 7'd6, 0, 1'b0);

        // Exhaustive sweep, random backpressure
        for (int s = 0; s < 2; s++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 8; bi++) begin
                    do_txn(ai[3:0], bi[2:0], s[0],
                           ref_prod(ai[3:0], bi[2:0], s[0]), 0, 1'b1);
                end
            end
        end

        chk("handshake_count", n_hs, n_acc);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
